// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
//
// Shared constants and types for the 64-bit LEGv8-style integer register
// file.
//   DEF_DATA_WIDTH : default width of each register and of every data bus
//   DEF_ADDR_WIDTH : default width of a register specifier
//   NUM_REGS       : number of architectural registers (2**DEF_ADDR_WIDTH)
//   XZR_IDX        : index of the register that acts as XZR when the
//                    REGISTER_FILE_ZERO_REG_EN macro is defined
//   reg_idx_t      : register specifier type
//   reg_data_t     : register data type
// ---------------------------------------------------------------------------
package register_file_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;
    localparam int XZR_IDX        = 31;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// ---------------------------------------------------------------------------
// register_file_read_port
//
// One purely combinational read port: selects one register out of the whole
// storage array by index. When REGISTER_FILE_ZERO_REG_EN is defined, reads
// of index XZR_IDX are forced to zero whatever the storage holds.
//
// Ports:
//   regs_i : full storage array (2**ADDR_WIDTH entries)
//   idx_i  : register index to read
//   data_o : selected register contents
//
// Configuration macro: REGISTER_FILE_ZERO_REG_EN
// ---------------------------------------------------------------------------
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] idx_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    // Plain index mux; XZR masking overrides the storage value.
    always_comb begin
        data_o = regs_i[idx_i];
`ifdef REGISTER_FILE_ZERO_REG_EN
        if (idx_i == ADDR_WIDTH'(XZR_IDX)) begin
            data_o = '0;
        end
`endif
    end

endmodule : register_file_read_port

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// General-purpose integer register file: two asynchronous read ports (A, B)
// and one synchronous write port (W). Synchronous active-high reset clears
// every register and takes priority over a write on the same edge. Reads
// have no write-to-read bypass: during a write cycle the old value is seen
// until the clock edge.
//
// Ports:
//   Clk   : clock, all state changes on the rising edge
//   Reset : synchronous, active-high reset
//   RA    : read-port A register index
//   RB    : read-port B register index
//   RW    : write-port register index
//   BusW  : write data
//   RegWr : write enable, active-high
//   BusA  : contents of register RA
//   BusB  : contents of register RB
//
// Configuration macro: REGISTER_FILE_ZERO_REG_EN
//   defined   -> register 31 is XZR: reads return 0, writes are dropped
//   undefined -> register 31 is an ordinary register
// ---------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    input  logic [ADDR_WIDTH-1:0] RW,
    input  logic [DATA_WIDTH-1:0] BusW,
    input  logic                  RegWr,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic                  wrAllowed;

    // With XZR enabled, a write to index 31 is simply dropped, so that
    // register stays at its reset value of zero and synthesis can trim it.
    always_comb begin
        wrAllowed = RegWr;
`ifdef REGISTER_FILE_ZERO_REG_EN
        if (RW == ADDR_WIDTH'(XZR_IDX)) begin
            wrAllowed = 1'b0;
        end
`endif
    end

    // Next-state array: unchanged except for the addressed entry on a write.
    always_comb begin
        regs_d = regs_q;
        if (wrAllowed) begin
            regs_d[RW] = BusW;
        end
    end

    // Reset wins over a simultaneous write, discarding that write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_a (
        .regs_i (regs_q),
        .idx_i  (RA),
        .data_o (BusA)
    );

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_b (
        .regs_i (regs_q),
        .idx_i  (RB),
        .data_o (BusB)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file. Keeps a plain array of 32 values as
// the architectural model and compares both read buses against it. Honors
// REGISTER_FILE_ZERO_REG_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_register_file;
    import register_file_pkg::*;

    logic      Clk;
    logic      Reset;
    reg_idx_t  RA;
    reg_idx_t  RB;
    reg_idx_t  RW;
    reg_data_t BusW;
    logic      RegWr;
    reg_data_t BusA;
    reg_data_t BusB;

    int checks;
    int errors;

    reg_data_t model [NUM_REGS];

    register_file dut (
        .Clk   (Clk),
        .Reset (Reset),
        .RA    (RA),
        .RB    (RB),
        .RW    (RW),
        .BusW  (BusW),
        .RegWr (RegWr),
        .BusA  (BusA),
        .BusB  (BusB)
    );

    // 10 time-unit clock period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    // Architectural expectation of a read at index idx.
    function automatic reg_data_t expRead(input int idx);
`ifdef REGISTER_FILE_ZERO_REG_EN
        if (idx == XZR_IDX) return '0;
`endif
        return model[idx];
    endfunction

    // Architectural effect of one clock edge.
    function automatic void modelEdge(input logic rst, input logic we,
                                      input int idx, input reg_data_t data);
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        end else if (we) begin
`ifdef REGISTER_FILE_ZERO_REG_EN
            if (idx != XZR_IDX) model[idx] = data;
`else
            model[idx] = data;
`endif
        end
    endfunction

    // Advance one rising edge, updating the model with the inputs present
    // at that edge, then step past it so outputs are stable.
    task automatic clockEdge();
        @(posedge Clk);
        modelEdge(Reset, RegWr, int'(RW), BusW);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        RegWr = 1'b1;
        RW    = 5'd7;
        BusW  = 64'hDEAD_BEEF;
        clockEdge();
        clockEdge();
        Reset = 1'b0;
        RegWr = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            RA = reg_idx_t'(i);
            RB = reg_idx_t'(NUM_REGS - 1 - i);
            #1;
            checks++;
            if (BusA !== 64'd0 || BusB !== 64'd0) begin
                errors++;
                $display("[TB] FAIL reset_sweep idx %0d: BusA=%0h BusB=%0h, required 0 and 0", i, BusA, BusB);
            end
        end
    endtask

    task automatic test_write_read();
        RegWr = 1'b1;
        RW    = 5'd2;
        BusW  = 64'd3456;
        clockEdge();
        RegWr = 1'b0;
        RA    = 5'd2;
        RB    = 5'd3;
        #1;
        checks++;
        if (BusA !== 64'd3456 || BusB !== 64'd0) begin
            errors++;
            $display("[TB] FAIL write_r2: BusA=%0d BusB=%0d, required 3456 and 0", BusA, BusB);
        end
        RegWr = 1'b1;
        RW    = 5'd19;
        BusW  = 64'd6453;
        clockEdge();
        RegWr = 1'b0;
        RA    = 5'd19;
        RB    = 5'd2;
        #1;
        checks++;
        if (BusA !== 64'd6453 || BusB !== 64'd3456) begin
            errors++;
            $display("[TB] FAIL write_r19: BusA=%0d BusB=%0d, required 6453 and 3456", BusA, BusB);
        end
        // Address swap with no clock in between must show up immediately.
        RA = 5'd2;
        RB = 5'd19;
        #1;
        checks++;
        if (BusA !== 64'd3456 || BusB !== 64'd6453) begin
            errors++;
            $display("[TB] FAIL comb_read: BusA=%0d BusB=%0d, required 3456 and 6453", BusA, BusB);
        end
    endtask

    task automatic test_reg31();
        RegWr = 1'b1;
        RW    = 5'd31;
        BusW  = 64'd6453;
        clockEdge();
        RegWr = 1'b0;
        RA    = 5'd31;
        RB    = 5'd19;
        #1;
        checks++;
`ifdef REGISTER_FILE_ZERO_REG_EN
        if (BusA !== 64'd0 || BusB !== 64'd6453) begin
            errors++;
            $display("[TB] FAIL reg31: BusA=%0d BusB=%0d, required 0 and 6453", BusA, BusB);
        end
`else
        if (BusA !== 64'd6453 || BusB !== 64'd6453) begin
            errors++;
            $display("[TB] FAIL reg31: BusA=%0d BusB=%0d, required 6453 and 6453", BusA, BusB);
        end
`endif
    endtask

    task automatic test_write_disable();
        RegWr = 1'b0;
        RW    = 5'd2;
        BusW  = 64'hFFFF;
        repeat (4) clockEdge();
        RA = 5'd2;
        RB = 5'd2;
        #1;
        checks++;
        if (BusA !== 64'd3456 || BusB !== 64'd3456) begin
            errors++;
            $display("[TB] FAIL write_disable: BusA=%0d BusB=%0d, required 3456 and 3456", BusA, BusB);
        end
    endtask

    task automatic test_read_during_write();
        reg_data_t oldVal;
        reg_data_t newVal;
        RW     = 5'd19;
        RA     = 5'd19;
        RB     = 5'd19;
        oldVal = expRead(19);
        newVal = {$urandom, $urandom};
        BusW   = newVal;
        RegWr  = 1'b1;
        #1;
        checks++;
        if (BusA !== oldVal || BusB !== oldVal) begin
            errors++;
            $display("[TB] FAIL rdw_before: BusA=%0h BusB=%0h, required %0h", BusA, BusB, oldVal);
        end
        clockEdge();
        RegWr = 1'b0;
        #1;
        checks++;
        if (BusA !== newVal || BusB !== newVal) begin
            errors++;
            $display("[TB] FAIL rdw_after: BusA=%0h BusB=%0h, required %0h", BusA, BusB, newVal);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            RW    = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            BusW  = {$urandom, $urandom};
            RegWr = ($urandom_range(0, 3) != 0);
            RA    = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            RB    = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            #1;
            checks++;
            if (BusA !== expRead(int'(RA)) || BusB !== expRead(int'(RB))) begin
                errors++;
                $display("[TB] FAIL random_read n=%0d RA=%0d RB=%0d: BusA=%0h BusB=%0h, required %0h and %0h",
                         n, RA, RB, BusA, BusB, expRead(int'(RA)), expRead(int'(RB)));
            end
            clockEdge();
        end
        RegWr = 1'b0;
        // Full sweep after the random traffic.
        for (int i = 0; i < NUM_REGS; i++) begin
            RA = reg_idx_t'(i);
            RB = reg_idx_t'(i);
            #1;
            checks++;
            if (BusA !== expRead(i) || BusB !== expRead(i)) begin
                errors++;
                $display("[TB] FAIL random_sweep idx %0d: BusA=%0h BusB=%0h, required %0h",
                         i, BusA, BusB, expRead(i));
            end
        end
    endtask

    task automatic test_reset_priority();
        // Put known content in R2, R5 and R19 first.
        RegWr = 1'b1;
        RW = 5'd2;  BusW = 64'd3456; clockEdge();
        RW = 5'd19; BusW = 64'd6453; clockEdge();
        RW = 5'd5;  BusW = 64'd11;   clockEdge();
        // Reset and write on the same edge: reset must win.
        Reset = 1'b1;
        RW    = 5'd5;
        BusW  = 64'd77;
        clockEdge();
        Reset = 1'b0;
        RegWr = 1'b0;
        RA    = 5'd5;
        RB    = 5'd2;
        #1;
        checks++;
        if (BusA !== 64'd0 || BusB !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_priority: R5=%0d R2=%0d, required 0 and 0", BusA, BusB);
        end
        RA = 5'd19;
        RB = 5'd31;
        #1;
        checks++;
        if (BusA !== 64'd0 || BusB !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_clear: R19=%0d R31=%0d, required 0 and 0", BusA, BusB);
        end
        // Model agrees with the cleared state across every index.
        for (int i = 0; i < NUM_REGS; i++) begin
            RA = reg_idx_t'(i);
            #1;
            checks++;
            if (BusA !== expRead(i)) begin
                errors++;
                $display("[TB] FAIL reset_model idx %0d: BusA=%0h, required %0h", i, BusA, expRead(i));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        Reset = 1'b1;
        RegWr = 1'b0;
        RA    = '0;
        RB    = '0;
        RW    = '0;
        BusW  = '0;

        test_reset();
        test_write_read();
        test_reg31();
        test_write_disable();
        test_read_during_write();
        test_random();
        test_reset_priority();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file
